aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Parametrised, iterative AES key-expansion engine for AES-128/192/256 selected per operation at run time. It accepts a cipher key with a start pulse and streams the Nr+1 128-bit round keys over a valid/ready interface. Words are generated one per cycle through a single shared SubWord path. The block sits between the key register file and the round datapath, replacing the fixed AES-128 key-round generator.

## Interface
- `MAX_NK`, default 8: largest supported key size in words (4, 6 or 8). Modes with Nk > MAX_NK are rejected, and the window is sized to MAX_NK words.
- `clk` input, 1 bit: clock.
- `nrst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a new expansion. Accepted only while `busy`=0.
- `key_len` input, 2 bits: mode. 00=AES-128, 01=AES-192, 10=AES-256, 11 is illegal. Sampled with `start`.
- `key_i` input, 256 bits: cipher key. Word 0 is in [255:224]. Unused low words are ignored. Sampled with `start`.
- `busy` output, 1 bit: an expansion is in progress.
- `err` output, 1 bit: one-cycle pulse when `start` arrives with an illegal or unsupported `key_len`.
- `rk_valid` output, 1 bit: a round key is presented.
- `rk_ready` input, 1 bit: the consumer accepts the round key.
- `rk_data` output, 128 bits: round key. Word 0 is in [127:96].
- `rk_idx` output, 4 bits: round index, 0..Nr.
- `rk_last` output, 1 bit: `rk_idx`==Nr. Qualified by `rk_valid`.

## Operation
- Nk/Nr: 4/10, 6/12, 8/14. Total words: 44, 52, 60.
- FSM states: IDLE, GEN, DRAIN.
  - IDLE→GEN on an accepted `start` with a legal mode. The key loads into the MAX_NK-word window, with word counter i=0 and rcon=8'h01.
  - An illegal mode leaves the FSM in IDLE and pulses `err`.
- GEN produces one word w[i] per cycle.
  - i<Nk: w[i] is key word i.
  - i≥Nk: w[i] = w[i−Nk] ^ temp.
    - If i mod Nk==0: temp = SubWord(RotWord(w[i−1])) ^ {rcon,24'h0}, then rcon = xtime(rcon).
    - Else if Nk==8 and i mod Nk==4: temp = SubWord(w[i−1]).
    - Else: temp = w[i−1].
- The window shifts each produced word in. Use an i mod Nk counter, not a divider.
- A 4-word collect register assembles round keys. When the 4th word of a key is collected, it transfers to the output register.
- Backpressure: if the output register is full and is not being drained that cycle, word production stalls. i, rcon and the window hold.
- After word 4·(Nr+1)−1, the FSM enters DRAIN. On the `rk_last` handshake it returns to IDLE.
- `start` while `busy`=1 is ignored, with no `err`.
- Reset mid-operation aborts immediately. All state clears, and no partial key is emitted after reset release.
- Reset values: `busy`=0, `err`=0, `rk_valid`=0, `rk_data`=0, `rk_idx`=0, `rk_last`=0, FSM=IDLE.

## Timing
- Edge 0 samples `start`. `busy`=1 from cycle 1. Word i is produced in cycle 1+i when no stall occurs.
- The first `rk_valid` (idx 0) asserts in cycle 5. With `rk_ready` held at 1, a new key appears every 4 cycles.
- With `rk_ready` held at 1, the `rk_last` valid cycle is 45, 53 or 61 for AES-128, 192 or 256. `busy` deasserts the cycle after the last handshake.
- `rk_data`, `rk_idx` and `rk_last` hold stable while `rk_valid`=1 and `rk_ready`=0.
- `rk_valid` may assert in the same cycle the previous key is accepted, so there is no bubble.
- `start` is accepted in the cycle `busy` is 0, which includes the cycle immediately after `busy` falls.
- `err` asserts in the cycle after the illegal `start`.
- SubWord is combinational within one cycle: 4 S-box instances feed a single XOR stage.

## Structure
- `aes_pkg` holds:
  - `key_len_e` enum
  - `nk_of()` / `nr_of()` functions
  - `xtime()` function
  - the S-box constant table
- Sub-module `aes_sbox`: 8-bit combinational S-box, instantiated 4 times for SubWord.
- The FSM, counters, window, collect register and output register live in `aes_key_expand`.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last`, in cycle 45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 keys; idx12 = e98ba06f448c773c8ecc720401002202, `rk_last`=1.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 keys; idx14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with random `rk_ready` toggling (50%) → the same 11 keys in order, stable while stalled, no drops or duplicates.
- `key_len`=11, or `key_len`=10 with MAX_NK=4 → `err` pulse, `busy` stays 0. `start` during `busy` → ignored, and the stream is unchanged.
- `nrst` asserted after idx 3 → all outputs 0 immediately. A new AES-128 `start` after release → the full correct 11-key stream from idx 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length modes, round parameters, GF(2^8) doubling
// and the forward S-box table used by the key-expansion engine.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  function automatic logic [3:0] nk_of(key_len_e kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry 0 sits in the top byte so a row reads left to right like the usual table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(logic [7:0] a);
    return SBOX[{~a, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box byte lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  assign s_o = sbox_lookup(a_i);

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle through a
// shared SubWord path, round keys streamed out over a valid/ready handshake.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_i,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int IDX6 = (MAX_NK >= 6) ? MAX_NK - 6 : 0;
  localparam int IDX8 = (MAX_NK >= 8) ? MAX_NK - 8 : 0;

  logic [1:0]   state_q, state_d;
  logic [31:0]  win_q [MAX_NK];
  logic [31:0]  colW_q [3];
  logic [5:0]   wordCnt_q;
  logic [2:0]   modCnt_q;
  logic [7:0]   rcon_q;
  logic [3:0]   nk_q;
  logic [5:0]   lastWord_q;
  logic         err_q;
  logic         rkValid_q;
  logic [127:0] rkData_q;
  logic [3:0]   rkIdx_q;
  logic         rkLast_q;

  logic [3:0]   nkNew;
  logic [5:0]   lastWordNew;
  logic         modeOk;
  logic         accept;
  logic         advance;
  logic         keyPhase;
  logic [31:0]  wOld;
  logic [31:0]  wPrev;
  logic [31:0]  sboxIn;
  logic [31:0]  subOut;
  logic [31:0]  temp;
  logic [31:0]  newWord;
  logic [31:0]  loadWin [MAX_NK];

  assign nkNew       = nk_of(key_len_e'(key_len));
  assign lastWordNew = {nr_of(key_len_e'(key_len)), 2'b00} + 6'd3;
  assign modeOk      = (key_len != 2'b11) && (nkNew <= 4'(MAX_NK));
  assign accept      = start && (state_q == S_IDLE);
  assign advance     = (state_q == S_GEN) && (!rkValid_q || rk_ready);
  assign keyPhase    = wordCnt_q < {2'b00, nk_q};

  // The active Nk words occupy the top of the window, so w[i-Nk] is always at a
  // fixed slot; during the key phase that same slot holds key word i.
  always_comb begin
    wOld = win_q[MAX_NK-4];
    if (nk_q == 4'd6) wOld = win_q[IDX6];
    else if (nk_q == 4'd8) wOld = win_q[IDX8];
  end

  assign wPrev  = win_q[MAX_NK-1];
  assign sboxIn = (modCnt_q == 3'd0) ? {wPrev[23:0], wPrev[31:24]} : wPrev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i(sboxIn[8*b +: 8]),
      .s_o(subOut[8*b +: 8])
    );
  end

  always_comb begin
    temp = wPrev;
    if (modCnt_q == 3'd0) temp = subOut ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && modCnt_q == 3'd4) temp = subOut;
    newWord = keyPhase ? wOld : (wOld ^ temp);
  end

  always_comb begin
    for (int p = 0; p < MAX_NK; p++) begin
      loadWin[p] = '0;
      for (int j = 0; j < MAX_NK; j++) begin
        if (p - j == MAX_NK - int'(nkNew)) loadWin[p] = key_i[255-32*j -: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && modeOk) state_d = S_GEN;
      S_GEN:   if (advance && wordCnt_q == lastWord_q) state_d = S_DRAIN;
      S_DRAIN: if (rkValid_q && rk_ready && rkLast_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      for (int p = 0; p < MAX_NK; p++) win_q[p] <= '0;
      for (int c = 0; c < 3; c++) colW_q[c] <= '0;
      wordCnt_q  <= '0;
      modCnt_q   <= '0;
      rcon_q     <= 8'h01;
      nk_q       <= 4'd4;
      lastWord_q <= '0;
      err_q      <= 1'b0;
      rkValid_q  <= 1'b0;
      rkData_q   <= '0;
      rkIdx_q    <= '0;
      rkLast_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !modeOk;

      if (accept && modeOk) begin
        for (int p = 0; p < MAX_NK; p++) win_q[p] <= loadWin[p];
        wordCnt_q  <= '0;
        modCnt_q   <= '0;
        rcon_q     <= 8'h01;
        nk_q       <= nkNew;
        lastWord_q <= lastWordNew;
      end else if (advance) begin
        for (int p = 0; p < MAX_NK - 1; p++) win_q[p] <= win_q[p+1];
        win_q[MAX_NK-1] <= newWord;
        wordCnt_q <= wordCnt_q + 6'd1;
        modCnt_q  <= ({1'b0, modCnt_q} == nk_q - 4'd1) ? 3'd0 : modCnt_q + 3'd1;
        if (!keyPhase && modCnt_q == 3'd0) rcon_q <= xtime(rcon_q);
        case (wordCnt_q[1:0])
          2'd0:    colW_q[0] <= newWord;
          2'd1:    colW_q[1] <= newWord;
          2'd2:    colW_q[2] <= newWord;
          default: ;
        endcase
      end

      // Advance already guarantees the output slot is free or draining this cycle.
      if (advance && wordCnt_q[1:0] == 2'd3) begin
        rkValid_q <= 1'b1;
        rkData_q  <= {colW_q[0], colW_q[1], colW_q[2], newWord};
        rkIdx_q   <= wordCnt_q[5:2];
        rkLast_q  <= (wordCnt_q == lastWord_q);
      end else if (rkValid_q && rk_ready) begin
        rkValid_q <= 1'b0;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign rk_valid = rkValid_q;
  assign rk_data  = rkData_q;
  assign rk_idx   = rkIdx_q;
  assign rk_last  = rkLast_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a FIPS-197 style key schedule model
// (S-box derived from GF(2^8) inversion) scores every presented round key.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start, start4;
  logic [1:0]   key_len;
  logic [255:0] key_i;
  logic         rk_ready;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy4, err4, rk_valid4, rk_last4;
  logic [127:0] rk_data4;
  logic [3:0]   rk_idx4;

  aes_key_expand #(.MAX_NK(8)) dut (
    .clk(clk), .nrst(nrst), .start(start), .key_len(key_len), .key_i(key_i),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  aes_key_expand #(.MAX_NK(4)) dut4 (
    .clk(clk), .nrst(nrst), .start(start4), .key_len(key_len), .key_i(key_i),
    .busy(busy4), .err(err4), .rk_valid(rk_valid4), .rk_ready(rk_ready),
    .rk_data(rk_data4), .rk_idx(rk_idx4), .rk_last(rk_last4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int           errors = 0;
  int           checks = 0;
  logic [7:0]   sbTab [256];
  logic [127:0] expKeys [15];
  int           expCount = 0;
  int           ptr = 0;
  bit           done = 0;
  int           firstRel = -1;
  int           lastRel = -1;
  int           startCyc = 0;
  bit           simDone = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbTab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(logic [31:0] v);
    return {sbTab[v[31:24]], sbTab[v[23:16]], sbTab[v[15:8]], sbTab[v[7:0]]};
  endfunction

  task automatic buildExpected(input logic [1:0] kl, input logic [255:0] key);
    int nk, nr, total;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    nk    = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    nr    = nk + 6;
    total = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expCount = nr + 1;
  endtask

  function automatic logic [255:0] randKey();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    return k;
  endfunction

  task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] key, input bit randReady,
                               input bit checkTiming, input int pokeAt);
    int guard;
    buildExpected(kl, key);
    @(posedge clk); #1;
    start = 1'b1; key_len = kl; key_i = key;
    rk_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_i = randKey();
    chk("busy_cycle1", busy, 1);
    chk("no_err_legal", err, 0);
    guard = 0;
    while (!done && guard < 1000) begin
      rk_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (guard == pokeAt) begin
        start = 1'b1; key_len = 2'b11; key_i = randKey();
      end
      @(posedge clk); #1;
      if (guard == pokeAt) begin
        start = 1'b0;
        chk("start_while_busy_no_err", err, 0);
        chk("start_while_busy_still_busy", busy, 1);
      end
      guard++;
    end
    chk("stream_complete", done, 1);
    chk("busy_after_last", busy, 0);
    if (checkTiming) begin
      chk("first_valid_cycle", 128'(firstRel), 128'd5);
      chk("last_valid_cycle", 128'(lastRel), 128'(4 * (expCount - 1) + 5));
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_rk_data"}, rk_data, 0);
    chk({tag, "_rk_idx"}, rk_idx, 0);
    chk({tag, "_rk_last"}, rk_last, 0);
  endtask

  task automatic illegalStart(input bit onDut4, input logic [1:0] kl);
    @(posedge clk); #1;
    if (onDut4) start4 = 1'b1; else start = 1'b1;
    key_len = kl;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
    chk(onDut4 ? "err4_pulse" : "err_pulse", onDut4 ? err4 : err, 1);
    chk(onDut4 ? "err4_busy" : "err_busy", onDut4 ? busy4 : busy, 0);
    @(posedge clk); #1;
    chk(onDut4 ? "err4_one_cycle" : "err_one_cycle", onDut4 ? err4 : err, 0);
    chk(onDut4 ? "err4_busy_after" : "err_busy_after", onDut4 ? busy4 : busy, 0);
  endtask

  task automatic compareLoop();
    while (!simDone) begin
      @(negedge clk);
      if (nrst && start && !busy) begin
        ptr = 0; done = 0; firstRel = -1; lastRel = -1; startCyc = cyc;
      end
      if (nrst && rk_valid) begin
        if (ptr >= expCount) begin
          chk("extra_key", 128'(ptr), 128'(expCount - 1));
        end else begin
          chk("rk_data", rk_data, expKeys[ptr]);
          chk("rk_idx", rk_idx, 128'(ptr));
          chk("rk_last", rk_last, (ptr == expCount - 1) ? 1 : 0);
          if (firstRel < 0) firstRel = cyc - startCyc;
          if (rk_ready) begin
            if (ptr == expCount - 1) begin
              done = 1; lastRel = cyc - startCyc;
            end
            ptr++;
          end
        end
      end
    end
  endtask

  task automatic mainSequence();
    int guard;
    nrst = 1'b0; start = 1'b0; start4 = 1'b0; key_len = 2'b00; key_i = '0; rk_ready = 1'b0;
    #12;
    checkOutput("reset");
    @(posedge clk); #1;
    nrst = 1'b1;

    buildSbox();
    chk("model_sbox_00", sbTab[8'h00], 8'h63);
    chk("model_sbox_53", sbTab[8'h53], 8'hed);
    buildExpected(2'd0, K128);
    chk("model_aes128_idx1", expKeys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_aes128_idx10", expKeys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    buildExpected(2'd1, K192);
    chk("model_aes192_idx12", expKeys[12], 128'he98ba06f448c773c8ecc720401002202);
    buildExpected(2'd2, K256);
    chk("model_aes256_idx14", expKeys[14], 128'hfe4890d1e6188d0b046df344706c631e);

    applyStimulus(2'd0, K128, 1'b0, 1'b1, -1);
    applyStimulus(2'd1, K192, 1'b0, 1'b1, -1);
    applyStimulus(2'd2, K256, 1'b0, 1'b1, -1);
    applyStimulus(2'd0, K128, 1'b1, 1'b0, -1);
    for (int n = 0; n < 4; n++)
      applyStimulus(2'($urandom_range(0, 2)), randKey(), 1'b1, 1'b0, -1);

    illegalStart(1'b0, 2'b11);
    illegalStart(1'b1, 2'b10);
    illegalStart(1'b1, 2'b01);
    @(posedge clk); #1;
    start4 = 1'b1; key_len = 2'b00; key_i = K128;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("dut4_aes128_busy", busy4, 1);
    chk("dut4_aes128_no_err", err4, 0);

    applyStimulus(2'd1, K192, 1'b0, 1'b1, 10);

    // Abort after idx 3 has been consumed, then rerun from a clean state.
    buildExpected(2'd0, K128);
    @(posedge clk); #1;
    start = 1'b1; key_len = 2'b00; key_i = K128; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (ptr < 4 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reached_idx3", (ptr >= 4) ? 1 : 0, 1);
    #2 nrst = 1'b0;
    #1 checkOutput("midreset");
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      chk("post_reset_no_valid", rk_valid, 0);
    end
    chk("post_reset_idle", busy, 0);
    applyStimulus(2'd0, K128, 1'b0, 1'b1, -1);

    repeat (2) @(posedge clk);
    simDone = 1;
  endtask

  initial begin
    fork
      compareLoop();
      mainSequence();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
